spim_core: RTL

Parametrised SPI master engine for the AI-channel sensor and converter interfaces. It replaces the fixed 24-bit, single-device serialiser, which had a hard-wired divider and one clock mode. It supports a configurable frame length, all four CPOL/CPHA modes, and MSB- or LSB-first order. It drives a runtime-set divider and selects one of NCS chip selects, with a start/busy/done handshake toward the channel controller FSM.

---
 rtl/spim_pkg.sv | 21 ++
 rtl/spim_clkgen.sv | 43 ++++
 rtl/spim_core.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/spim_pkg.sv
// Shared definitions for the SPI master engine.
// Contents: FSM state enum, divider floor, effective frame-length helper.
package spim_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShift,
    StHold,
    StGap
  } state_e;

  // Floor on the half-period divider; leaves room for the 2-flop MISO synchroniser.
  localparam int unsigned MIN_DIV = 2;

  // A programmed length of 0 selects the full data width.
  function automatic int unsigned eff_len(input int unsigned len, input int unsigned dwidth);
    return (len == 0) ? dwidth : len;
  endfunction

endpackage

// File: rtl/spim_clkgen.sv
// Half-period timer for the SPI master.
// Ports:
//   clk_sys, rst_sys_n : system clock, synchronous active-low reset
//   enable             : counter runs while high, held at zero otherwise
//   div_val            : half-period = max(div_val, MIN_DIV) + 1 cycles
//   tick               : one-cycle pulse in the last cycle of each half-period
//   sample             : tick delayed by 2 cycles (MISO sampling strobe)
module spim_clkgen
  import spim_pkg::*;
#(
  parameter int unsigned DIVW = 8
) (
  input  logic            clk_sys,
  input  logic            rst_sys_n,
  input  logic            enable,
  input  logic [DIVW-1:0] div_val,
  output logic            tick,
  output logic            sample
);

  logic [DIVW-1:0] cnt_q, cnt_d;
  logic [DIVW-1:0] div_eff;
  logic [1:0]      dly_q;

  always_comb begin
    div_eff = (div_val < DIVW'(MIN_DIV)) ? DIVW'(MIN_DIV) : div_val;
    tick    = enable && (cnt_q == div_eff);
    cnt_d   = (!enable || tick) ? '0 : cnt_q + DIVW'(1);
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_sys_n) begin
      cnt_q <= '0;
      dly_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      dly_q <= {dly_q[0], tick};
    end
  end

  assign sample = dly_q[1];

endmodule

// File: rtl/spim_core.sv
// SPI master engine: configurable frame length, CPOL/CPHA, bit order, divider
// and chip select, with a start/busy/done handshake.
// Ports:
//   clk_sys, rst_sys_n        : system clock, synchronous active-low reset
//   start                     : transfer request (sampled while idle)
//   cpol, cpha, lsb_first     : clock mode and bit order
//   div_val, len, cs_sel      : divider, frame length (0 = DWIDTH), device select
//   tx_data / rx_data         : right-aligned transmit / received words
//   busy, done                : transfer in progress / one-cycle completion pulse
//   spi_cs_n, spi_clk,
//   spi_mosi, spi_miso        : SPI bus
module spim_core
  import spim_pkg::*;
#(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned NCS    = 4,
  parameter int unsigned DIVW   = 8,
  localparam int unsigned LW    = $clog2(DWIDTH + 1),
  localparam int unsigned CSW   = (NCS > 1) ? $clog2(NCS) : 1
) (
  input  logic              clk_sys,
  input  logic              rst_sys_n,
  input  logic              start,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [DIVW-1:0]   div_val,
  input  logic [LW-1:0]     len,
  input  logic [CSW-1:0]    cs_sel,
  input  logic [DWIDTH-1:0] tx_data,
  input  logic              spi_miso,
  output logic              busy,
  output logic              done,
  output logic [DWIDTH-1:0] rx_data,
  output logic [NCS-1:0]    spi_cs_n,
  output logic              spi_clk,
  output logic              spi_mosi
);

  localparam int unsigned IW = $clog2(DWIDTH);
  localparam int unsigned EW = LW + 1;

  state_e            state_q, state_d;
  logic              cpha_q, cpha_d, lsb_q, lsb_d;
  logic [DIVW-1:0]   div_q, div_d;
  logic [LW-1:0]     len_q, len_d;
  logic [DWIDTH-1:0] tx_q, tx_d, rx_sh_q, rx_sh_d, rx_q, rx_d;
  logic [EW-1:0]     edge_q, edge_d;
  logic [LW-1:0]     ntx_q, ntx_d, nrx_q, nrx_d;
  logic              pend_q, pend_d, done_q, done_d;
  logic [NCS-1:0]    cs_n_q, cs_n_d;
  logic              clk_q, clk_d, mosi_q, mosi_d;
  logic              sync1_q, sync2_q;

  logic              tick, sample, clk_en, cs_ok;
  logic [LW-1:0]     start_len;
  int unsigned       len_i;
  logic [IW-1:0]     first_pos, tx_pos, rx_pos;
  logic [EW-1:0]     last_edge;
  logic              edge_now, leading, drive_now, samp_now;

  assign clk_en = (state_q != StIdle);

  spim_clkgen #(
    .DIVW (DIVW)
  ) u_clkgen (
    .clk_sys   (clk_sys),
    .rst_sys_n (rst_sys_n),
    .enable    (clk_en),
    .div_val   (div_q),
    .tick      (tick),
    .sample    (sample)
  );

  always_comb begin
    cs_ok     = (32'(cs_sel) < NCS);
    start_len = LW'(eff_len(32'(len), DWIDTH));
    first_pos = lsb_first ? '0 : IW'(32'(start_len) - 1);
    len_i     = 32'(len_q);
    tx_pos    = lsb_q ? IW'(ntx_q) : IW'(len_i - 1 - 32'(ntx_q));
    rx_pos    = lsb_q ? IW'(nrx_q) : IW'(len_i - 1 - 32'(nrx_q));
    last_edge = EW'(2 * len_i);
    // Edge e = edge_q: even edges leave the idle level (leading), odd edges return.
    edge_now  = tick && ((state_q == StSetup) ||
                         ((state_q == StShift) && (edge_q != last_edge)));
    leading   = ~edge_q[0];
    // CPHA=0 drives on trailing edges except the final one (first bit went out at SETUP).
    drive_now = edge_now && (cpha_q ? leading
                                    : (!leading && (edge_q != last_edge - EW'(1))));
    samp_now  = edge_now && (cpha_q ? !leading : leading);

    state_d = state_q;
    cpha_d  = cpha_q;
    lsb_d   = lsb_q;
    div_d   = div_q;
    len_d   = len_q;
    tx_d    = tx_q;
    rx_sh_d = rx_sh_q;
    rx_d    = rx_q;
    edge_d  = edge_q;
    ntx_d   = ntx_q;
    nrx_d   = nrx_q;
    pend_d  = pend_q;
    done_d  = 1'b0;
    cs_n_d  = cs_n_q;
    clk_d   = clk_q;
    mosi_d  = mosi_q;

    // The sampling edge only arms a capture; the synchronised bit is taken 2 cycles later.
    if (sample && pend_q) begin
      rx_sh_d[rx_pos] = sync2_q;
      nrx_d           = nrx_q + LW'(1);
      pend_d          = 1'b0;
    end
    if (edge_now) begin
      clk_d  = ~clk_q;
      edge_d = edge_q + EW'(1);
    end
    if (drive_now) begin
      mosi_d = tx_q[tx_pos];
      ntx_d  = ntx_q + LW'(1);
    end
    if (samp_now) pend_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        clk_d = cpol;
        if (start && cs_ok) begin
          state_d = StSetup;
          cpha_d  = cpha;
          lsb_d   = lsb_first;
          div_d   = div_val;
          len_d   = start_len;
          tx_d    = tx_data;
          rx_sh_d = '0;
          edge_d  = '0;
          nrx_d   = '0;
          pend_d  = 1'b0;
          cs_n_d  = ~(NCS'(1) << cs_sel);
          if (!cpha) begin
            mosi_d = tx_data[first_pos];
            ntx_d  = LW'(1);
          end else begin
            ntx_d  = '0;
          end
        end
      end
      StSetup: if (tick) state_d = StShift;
      StShift: if (tick && (edge_q == last_edge)) state_d = StHold;
      StHold: begin
        if (tick) begin
          state_d = StGap;
          cs_n_d  = '1;
        end
      end
      StGap: begin
        if (tick) begin
          state_d = StIdle;
          done_d  = 1'b1;
          rx_d    = rx_sh_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_sys_n) begin
      state_q <= StIdle;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
      div_q   <= '0;
      len_q   <= '0;
      tx_q    <= '0;
      rx_sh_q <= '0;
      rx_q    <= '0;
      edge_q  <= '0;
      ntx_q   <= '0;
      nrx_q   <= '0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      cs_n_q  <= '1;
      clk_q   <= 1'b0;
      mosi_q  <= 1'b0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cpha_q  <= cpha_d;
      lsb_q   <= lsb_d;
      div_q   <= div_d;
      len_q   <= len_d;
      tx_q    <= tx_d;
      rx_sh_q <= rx_sh_d;
      rx_q    <= rx_d;
      edge_q  <= edge_d;
      ntx_q   <= ntx_d;
      nrx_q   <= nrx_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      cs_n_q  <= cs_n_d;
      clk_q   <= clk_d;
      mosi_q  <= mosi_d;
      sync1_q <= spi_miso;
      sync2_q <= sync1_q;
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign rx_data  = rx_q;
  assign spi_cs_n = cs_n_q;
  assign spi_clk  = clk_q;
  assign spi_mosi = mosi_q;

endmodule
